oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite-DMA engine for the Dendy core. It is the writer side of the OAM port that the PPU reads through oama/oamd.
- A CPU write to $4014 selects a source page. The block then stalls the CPU, copies 256 bytes from that page on the CPU bus into OAM, and releases the CPU.
- It sits between the cpu bus mux and the OAM RAM write port, and is clocked from the CPU clock domain.

Parameters:
- DMA_REG, 16'h4014, CPU address that triggers DMA.
- OAMADDR_REG, 16'h2003, CPU address of the OAM start-address register (used only with the optional feature).

Ports:
- clock25  in  1  system clock; the CPU runs on it.
- reset  in  1  asynchronous reset, active-high.
- ce_cpu  in  1  CPU clock-enable. All state advances only when this is 1.
- cpu_a  in  16  CPU address bus.
- cpu_d  in  8  CPU write data.
- cpu_w  in  1  CPU write strobe, qualified by ce_cpu.
- rdy  out  1  1 = CPU may run; 0 = CPU halted.
- dma_a  out  16  address the DMA drives onto the CPU bus.
- dma_oe  out  1  1 = bus mux selects dma_a instead of the CPU address.
- dma_i  in  8  bus read data. It is registered, valid on the ce_cpu tick after dma_a was presented.
- oam_wa  out  8  OAM write address.
- oam_wd  out  8  OAM write data.
- oam_we  out  1  OAM write strobe, one clock25 wide, on a ce_cpu tick.
- busy  out  1  DMA in progress (any state except IDLE).

Behaviour:
- Reset values:
  - rdy = 1, dma_oe = 0, oam_we = 0, busy = 0.
  - dma_a = 0, oam_wa = 0, oam_wd = 0.
  - State = IDLE, page = 0, count = 0, start = 0, odd = 0.
- odd toggles on every ce_cpu tick. It models the CPU get/put cycle parity.
- Trigger: cpu_w & ce_cpu & cpu_a == DMA_REG in IDLE:
  - Latch page <= cpu_d.
  - count <= 0.
  - Go to HALT.
- HALT (1 tick):
  - rdy = 0; the CPU finishes its current write.
  - Next state is ALIGN if odd == 1 after this tick's toggle, else READ.
- ALIGN (1 tick): idle tick with rdy = 0. Next state READ.
- READ (1 tick):
  - dma_oe = 1, dma_a = {page, count}. Next state WRITE.
- WRITE (1 tick):
  - Capture oam_wd <= dma_i, oam_wa <= start + count (8-bit wrap), pulse oam_we.
  - count <= count + 1.
  - If count was 255, go to IDLE and raise rdy; otherwise go to READ.
- Total stall is 513 ticks (even start) or 514 ticks (odd start), counted from the trigger tick to the tick where rdy returns to 1.
- rdy, dma_oe and busy are registered and change only on ce_cpu ticks.
- A trigger write while busy is ignored; the page is not relatched.
- count is 9 bits internally so the terminal test is count == 255 before increment. oam_wa wraps mod 256.
- Page 8'hFF reads $FF00..$FFFF. dma_a must not wrap into page 0.
- Reset mid-transfer aborts immediately:
  - Outputs return to reset values.
  - Partial OAM contents are left as written.
- ce_cpu low holds all state. It may stay low for any number of clock25 cycles.

Optional Feature:
- Macro: OAM_DMA_OAMADDR_EN.
- With the macro defined:
  - A CPU write to OAMADDR_REG (on a ce_cpu tick, while not busy) latches start <= cpu_d.
  - DMA bytes go to start, start+1, …, wrapping at 255.
  - start is unchanged after DMA.
- Without the macro:
  - start is tied to 0; OAMADDR_REG writes are ignored.
  - Byte i always goes to OAM[i].

Test Plan:
- Even-parity trigger: write 8'h02 to $4014 with page $0200 holding i ^ 8'h5A. Required: OAM[i] = i ^ 8'h5A for all i; rdy low for exactly 513 ce_cpu ticks; 256 oam_we pulses.
- Odd-parity trigger: same transfer started one tick later. Required: rdy low for 514 ticks; ALIGN is visited once; data is identical.
- Re-trigger during DMA: write 8'h03 to $4014 at transfer byte 100. Required: ignored; all 256 bytes are still sourced from page $02.
- Page $FF boundary: required dma_a sequence runs $FF00..$FFFF; the last write is oam_wa = 8'hFF; no read from $0000.
- Reset mid-transfer: assert reset at byte 40. Required: rdy = 1, busy = 0, dma_oe = 0 immediately; OAM[0..39] written, OAM[40..] untouched. A new trigger after reset then completes normally.
- With OAM_DMA_OAMADDR_EN: write 8'hF0 to $2003, then DMA page $02. Required: byte 0 goes to OAM[F0], byte 15 to OAM[FF], byte 16 to OAM[00]. Without the macro, the same stimulus gives byte 0 → OAM[00].

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine for the Dendy core.
// A CPU write to DMA_REG latches a source page. The engine then halts the CPU,
// copies 256 bytes from {page, 8'h00..8'hFF} into OAM and releases the CPU.
// Optional feature macro: OAM_DMA_OAMADDR_EN. When defined, a CPU write to
// OAMADDR_REG sets the OAM start address used by the copy. When undefined,
// the start address is held at zero.
module oam_dma #(
  parameter logic [15:0] DMA_REG     = 16'h4014,
  parameter logic [15:0] OAMADDR_REG = 16'h2003
) (
  input  logic        clock25,
  input  logic        reset,
  input  logic        ce_cpu,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_w,
  output logic        rdy,
  output logic [15:0] dma_a,
  output logic        dma_oe,
  input  logic [7:0]  dma_i,
  output logic [7:0]  oam_wa,
  output logic [7:0]  oam_wd,
  output logic        oam_we,
  output logic        busy
);

`ifdef OAM_DMA_OAMADDR_EN
  localparam logic START_EN = 1'b1;
`else
  localparam logic START_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  page_r;
  logic [7:0]  page_s;
  // One bit wider than a byte index so the last byte can be recognised
  // before the increment without any wrap ambiguity.
  logic [8:0]  count_r;
  logic [8:0]  count_s;
  logic [7:0]  start_r;
  logic        odd_r;

  logic        rdy_r;
  logic        busy_r;
  logic        dma_oe_r;
  logic [15:0] dma_a_r;
  logic [7:0]  oam_wa_r;
  logic [7:0]  oam_wd_r;
  logic        oam_we_r;

  logic        trigger_s;
  logic        oamaddr_wr_s;
  logic        write_tick_s;

  // A trigger is only honoured from IDLE; writes to $4014 while busy are dropped.
  assign trigger_s    = ce_cpu & cpu_w & (cpu_a == DMA_REG) & (state_r == ST_IDLE);
  assign oamaddr_wr_s = START_EN & ce_cpu & cpu_w & (cpu_a == OAMADDR_REG) & (state_r == ST_IDLE);
  assign write_tick_s = ce_cpu & (state_r == ST_WRITE);

  // Next-state and datapath-next logic; only sampled into registers on ce_cpu ticks.
  always_comb begin
    state_s = state_r;
    page_s  = page_r;
    count_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          state_s = ST_HALT;
          page_s  = cpu_d;
          count_s = 9'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HALT: begin
        // odd toggles this tick; an odd phase afterwards needs one align tick
        // so that reads land on get cycles.
        if (!odd_r) begin
          state_s = ST_ALIGN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_ALIGN: begin
        state_s = ST_READ;
      end
      ST_READ: begin
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        count_s = count_r + 9'd1;
        if (count_r == 9'd255) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_READ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, page, byte counter and get/put parity register.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      page_r  <= 8'd0;
      count_r <= 9'd0;
      odd_r   <= 1'b0;
    end else if (ce_cpu) begin
      state_r <= state_s;
      page_r  <= page_s;
      count_r <= count_s;
      odd_r   <= ~odd_r;
    end
  end

  // OAM start address; stays zero unless the start-address feature is built in.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      start_r <= 8'd0;
    end else if (oamaddr_wr_s) begin
      start_r <= cpu_d;
    end
  end

  // CPU-facing handshake outputs, registered from the next state.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      rdy_r    <= 1'b1;
      busy_r   <= 1'b0;
      dma_oe_r <= 1'b0;
    end else if (ce_cpu) begin
      rdy_r    <= (state_s == ST_IDLE);
      busy_r   <= (state_s != ST_IDLE);
      dma_oe_r <= (state_s == ST_READ);
    end
  end

  // Bus read address, presented for the whole READ tick; page FF stays in page FF.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      dma_a_r <= 16'd0;
    end else if (ce_cpu && (state_s == ST_READ)) begin
      dma_a_r <= {page_s, count_s[7:0]};
    end
  end

  // OAM write address and data captured on the WRITE tick.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      oam_wa_r <= 8'd0;
      oam_wd_r <= 8'd0;
    end else if (write_tick_s) begin
      oam_wa_r <= start_r + count_r[7:0];
      oam_wd_r <= dma_i;
    end
  end

  // OAM write strobe: exactly one clock25 cycle following each WRITE tick.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      oam_we_r <= 1'b0;
    end else begin
      oam_we_r <= write_tick_s;
    end
  end

  assign rdy    = rdy_r;
  assign busy   = busy_r;
  assign dma_oe = dma_oe_r;
  assign dma_a  = dma_a_r;
  assign oam_wa = oam_wa_r;
  assign oam_wd = oam_wd_r;
  assign oam_we = oam_we_r;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed/randomized bench for oam_dma with a behavioural
// reference (stall length from start parity, OAM image from page contents).
module tb_oam_dma;

  logic        clock25 = 1'b0;
  logic        reset;
  logic        ce_cpu;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_w;
  logic        rdy;
  logic [15:0] dma_a;
  logic        dma_oe;
  logic [7:0]  dma_i;
  logic [7:0]  oam_wa;
  logic [7:0]  oam_wd;
  logic        oam_we;
  logic        busy;

  oam_dma dut (
    .clock25 (clock25),
    .reset   (reset),
    .ce_cpu  (ce_cpu),
    .cpu_a   (cpu_a),
    .cpu_d   (cpu_d),
    .cpu_w   (cpu_w),
    .rdy     (rdy),
    .dma_a   (dma_a),
    .dma_oe  (dma_oe),
    .dma_i   (dma_i),
    .oam_wa  (oam_wa),
    .oam_wd  (oam_wd),
    .oam_we  (oam_we),
    .busy    (busy)
  );

  always #5 clock25 = ~clock25;

`ifdef OAM_DMA_OAMADDR_EN
  localparam bit START_EN = 1'b1;
`else
  localparam bit START_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [65536];
  logic [7:0]  oam_seen [256];
  bit          written [256];
  logic [15:0] reads [$];
  int          pulses;
  int          tick_cnt;
  logic [7:0]  last_wa;
  logic        pre_rdy;
  logic        pre_oe;
  logic [15:0] pre_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU tick after a random number of idle clock25 cycles; also acts as
  // the bus/OAM model: registered bus read data and OAM write capture.
  task automatic tick();
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap + 1) @(negedge clock25);
    ce_cpu = 1'b1;
    #1;
    pre_rdy = rdy;
    pre_oe  = dma_oe;
    pre_a   = dma_a;
    @(posedge clock25);
    #1;
    ce_cpu = 1'b0;
    tick_cnt++;
    if (pre_oe) reads.push_back(pre_a);
    dma_i = mem[pre_oe ? pre_a : cpu_a];
    if (oam_we) begin
      oam_seen[oam_wa] = oam_wd;
      written[oam_wa]  = 1'b1;
      last_wa          = oam_wa;
      pulses++;
    end
  endtask

  task automatic align(input int par);
    if ((tick_cnt % 2) != par) tick();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    reads.delete();
    pulses = 0;
  endtask

  // Trigger a transfer and follow it; abort_at >= 0 returns after that many writes.
  task automatic run_dma(input logic [7:0] pg, input logic [7:0] st,
                         input int retrig_at, input int abort_at, input string tag);
    int trig_idx, lows, bad, badr;
    bit retrig_done;
    logic [7:0] ib;
    logic [7:0] oa;
    clear_obs();
    cpu_a = 16'h4014; cpu_d = pg; cpu_w = 1'b1;
    trig_idx = tick_cnt;
    tick();
    cpu_w = 1'b0;
    lows = 0;
    retrig_done = 1'b0;
    forever begin
      if (abort_at >= 0 && pulses == abort_at) return;
      if (retrig_at >= 0 && !retrig_done && pulses == retrig_at) begin
        cpu_a = 16'h4014; cpu_d = 8'h03; cpu_w = 1'b1; retrig_done = 1'b1;
      end
      tick();
      cpu_w = 1'b0;
      if (pre_rdy) break;
      lows++;
      if (lows > 1000) break;
    end
    check({tag, " stall"}, lows, 513 + (trig_idx % 2));
    check({tag, " pulses"}, pulses, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      oa = st + ib;
      if (!written[oa] || oam_seen[oa] !== mem[{pg, ib}]) bad++;
    end
    check({tag, " data_bad"}, bad, 0);
    check({tag, " reads"}, reads.size(), 256);
    badr = 0;
    for (int k = 0; k < reads.size(); k++) begin
      ib = k[7:0];
      if (reads[k] !== {pg, ib}) badr++;
    end
    check({tag, " read_seq_bad"}, badr, 0);
    check({tag, " rdy_end"}, rdy, 1'b1);
    check({tag, " busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int wcnt, wlow, bad;
    logic [7:0] pg;
    logic [7:0] st;
    logic [7:0] ib;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      mem[{8'h02, ib}] = ib ^ 8'h5A;
      mem[{8'h03, ib}] = ~(ib ^ 8'h5A);
    end

    reset = 1'b1; ce_cpu = 1'b0; cpu_w = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00;
    dma_i = 8'h00; tick_cnt = 0; pulses = 0; last_wa = 8'h00;
    repeat (3) @(negedge clock25);
    #1;
    check("rst rdy", rdy, 1'b1);
    check("rst dma_oe", dma_oe, 1'b0);
    check("rst oam_we", oam_we, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst dma_a", dma_a, 16'h0000);
    check("rst oam_wa", oam_wa, 8'h00);
    check("rst oam_wd", oam_wd, 8'h00);
    @(negedge clock25);
    reset = 1'b0;

    align(0);
    run_dma(8'h02, 8'h00, -1, -1, "even");
    align(1);
    run_dma(8'h02, 8'h00, -1, -1, "odd");
    align(int'($urandom_range(0, 1)));
    run_dma(8'h02, 8'h00, 100, -1, "retrig");
    run_dma(8'hFF, 8'h00, -1, -1, "pageFF");
    check("pageFF last_read", reads[reads.size() - 1], 16'hFFFF);
    check("pageFF last_wa", last_wa, 8'hFF);
    pg = 8'($urandom);
    run_dma(pg, 8'h00, -1, -1, "rand_page");

    // Reset in the middle of a transfer.
    run_dma(8'h02, 8'h00, -1, 40, "abort");
    @(posedge clock25);
    @(negedge clock25);
    reset = 1'b1;
    #1;
    check("abort rdy", rdy, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort dma_oe", dma_oe, 1'b0);
    check("abort oam_we", oam_we, 1'b0);
    wcnt = 0; wlow = 0; bad = 0;
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      if (written[i]) wcnt++;
      if (i < 40 && written[i]) wlow++;
      if (i < 40 && oam_seen[i] !== mem[{8'h02, ib}]) bad++;
    end
    check("abort written_total", wcnt, 40);
    check("abort written_low", wlow, 40);
    check("abort data_bad", bad, 0);
    repeat (2) @(negedge clock25);
    reset = 1'b0;
    tick_cnt = 0;
    dma_i = 8'h00;
    pg = 8'($urandom);
    run_dma(pg, 8'h00, -1, -1, "post_reset");

    // OAM start address write, then a page 02 copy.
    cpu_a = 16'h2003; cpu_d = 8'hF0; cpu_w = 1'b1;
    tick();
    cpu_w = 1'b0;
    st = START_EN ? 8'hF0 : 8'h00;
    run_dma(8'h02, st, -1, -1, "oamaddr");
    check("oamaddr byte0", oam_seen[st], mem[16'h0200]);
    check("oamaddr byte15", oam_seen[st + 8'd15], mem[16'h020F]);
    check("oamaddr byte16", oam_seen[st + 8'd16], mem[16'h0210]);
    pg = 8'($urandom);
    run_dma(pg, st, -1, -1, "start_kept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
